// File: rtl/dbl_pkg.sv
// Shared constants and state encoding for the fixed-to-double converter.
// The exponent counter only ever holds 0..52, so six bits are enough.
package dbl_pkg;

  localparam int DBL_BIAS  = 1023;
  localparam int DBL_EXP_W = 11;
  localparam int DBL_MAN_W = 52;
  localparam int E_W       = 6;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DONE
  } state_t;

endpackage

// File: rtl/double_pack.sv
// Packs a normalised sign/exponent/magnitude triple into an IEEE-754 double.
// The magnitude MSB is the hidden bit, so it is dropped from the mantissa.
module double_pack
  import dbl_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int FRAC_BITS = 0
) (
  input  logic            sign,
  input  logic [E_W-1:0]  e,
  input  logic [IN_W-1:0] mag,
  output logic [63:0]     word
);

  logic [11:0]          exp12;
  logic [DBL_MAN_W-1:0] man;
  logic                 unused_hidden;

  assign unused_hidden = mag[IN_W-1];

  always_comb begin
    exp12 = 12'(e) + 12'(DBL_BIAS) - 12'(FRAC_BITS);
    man   = '0;
    man[DBL_MAN_W-1 -: IN_W-1] = mag[IN_W-2:0];
    word  = {sign, exp12[DBL_EXP_W-1:0], man};
  end

endmodule

// File: rtl/fixed_to_double_seq.sv
// Sequential fixed-point to IEEE-754 double converter.
// Normalises one left shift per cycle; conversion is exact.
module fixed_to_double_seq
  import dbl_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int FRAC_BITS = 0,
  parameter int TWOS_COMP = 1
) (
  input  logic            clk_operation,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [63:0]     out_double,
  output logic            busy
);

  localparam logic TC = (TWOS_COMP != 0);

  state_t          state, state_n;
  logic [IN_W-1:0] mag, mag_n;
  logic [E_W-1:0]  e, e_n;
  logic            sign, sign_n;
  logic [63:0]     res, res_n;
  logic [63:0]     packed_w;

  double_pack #(
    .IN_W      (IN_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_pack (
    .sign (sign),
    .e    (e),
    .mag  (mag),
    .word (packed_w)
  );

  always_ff @(posedge clk_operation) begin
    if (rst) begin
      state <= IDLE;
      mag   <= '0;
      e     <= '0;
      sign  <= 1'b0;
      res   <= '0;
    end else begin
      state <= state_n;
      mag   <= mag_n;
      e     <= e_n;
      sign  <= sign_n;
      res   <= res_n;
    end
  end

  always_comb begin
    state_n = state;
    mag_n   = mag;
    e_n     = e;
    sign_n  = sign;
    res_n   = res;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          state_n = NORM;
          sign_n  = in_data[IN_W-1];
          e_n     = E_W'(IN_W-1);
          if (TC)
            mag_n = in_data[IN_W-1] ? -in_data : in_data;
          else
            mag_n = {1'b0, in_data[IN_W-2:0]};
        end
      end
      NORM: begin
        // Two's complement has no negative zero, so force +0.0 there
        if (mag == '0) begin
          res_n   = {sign & ~TC, 63'b0};
          state_n = DONE;
        end else if (mag[IN_W-1]) begin
          res_n   = packed_w;
          state_n = DONE;
        end else begin
          mag_n = mag << 1;
          e_n   = e - E_W'(1);
        end
      end
      DONE: begin
        if (out_ready)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign in_ready   = (state == IDLE) && !rst;
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign out_double = res;

endmodule

// File: tb/tb_fixed_to_double_seq.sv
// Scoreboard bench: three converter configurations, directed vectors,
// backpressure and mid-conversion reset.
module tb_fixed_to_double_seq;

  typedef struct {
    logic [63:0] d;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  iv, ir, ov, ordy, bsy;
  logic [15:0] idat0, idat1, idat2;
  logic [63:0] od0, od1, od2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int hs[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fixed_to_double_seq #(.IN_W(16), .FRAC_BITS(0), .TWOS_COMP(1)) u0 (
    .clk_operation (clk), .rst (rst),
    .in_valid (iv[0]), .in_ready (ir[0]), .in_data (idat0),
    .out_valid (ov[0]), .out_ready (ordy[0]), .out_double (od0),
    .busy (bsy[0])
  );

  fixed_to_double_seq #(.IN_W(16), .FRAC_BITS(0), .TWOS_COMP(0)) u1 (
    .clk_operation (clk), .rst (rst),
    .in_valid (iv[1]), .in_ready (ir[1]), .in_data (idat1),
    .out_valid (ov[1]), .out_ready (ordy[1]), .out_double (od1),
    .busy (bsy[1])
  );

  fixed_to_double_seq #(.IN_W(16), .FRAC_BITS(15), .TWOS_COMP(1)) u2 (
    .clk_operation (clk), .rst (rst),
    .in_valid (iv[2]), .in_ready (ir[2]), .in_data (idat2),
    .out_valid (ov[2]), .out_ready (ordy[2]), .out_double (od2),
    .busy (bsy[2])
  );

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Monitor: pops an expectation whenever a result is accepted
  always @(negedge clk) begin
    exp_t        x;
    logic        hit;
    logic [63:0] d;
    for (int k = 0; k < 3; k++) begin
      if (!rst && ov[k] && ordy[k]) begin
        hit = 1'b0;
        d   = (k == 0) ? od0 : (k == 1) ? od1 : od2;
        case (k)
          0: if (q0.size() > 0) begin x = q0.pop_front(); hit = 1'b1; end
          1: if (q1.size() > 0) begin x = q1.pop_front(); hit = 1'b1; end
          default:
             if (q2.size() > 0) begin x = q2.pop_front(); hit = 1'b1; end
        endcase
        if (!hit) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output dut%0d got=%h exp=none", k, d);
        end else begin
          chk($sformatf("data_dut%0d", k), d, x.d);
          if (x.lat >= 0)
            chk($sformatf("latency_dut%0d", k), 64'(cyc - hs[k]),
                64'(x.lat));
        end
      end
    end
  end

  task automatic send(input int k, input logic [15:0] d,
                      input logic [63:0] e, input int lat);
    int   n;
    exp_t x;
    @(negedge clk);
    case (k)
      0: idat0 = d;
      1: idat1 = d;
      default: idat2 = d;
    endcase
    iv[k] = 1'b1;
    n = 0;
    while (!ir[k] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ir[k]) begin
      tests++;
      fails++;
      $display("FAIL in_ready_timeout dut%0d got=0 exp=1", k);
      iv[k] = 1'b0;
      return;
    end
    x.d   = e;
    x.lat = lat;
    case (k)
      0: q0.push_back(x);
      1: q1.push_back(x);
      default: q2.push_back(x);
    endcase
    @(posedge clk);
    #1;
    hs[k] = cyc;
    iv[k] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    iv    = '0;
    ordy  = 3'b111;
    idat0 = '0;
    idat1 = '0;
    idat2 = '0;
    rst   = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_out_valid", 64'(ov), 64'd0);
    chk("rst_busy", 64'(bsy), 64'd0);
    chk("rst_in_ready", 64'(ir), 64'd0);
    chk("rst_out_double", od0, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(ir), 64'h7);

    send(0, 16'h0001, 64'h3FF0000000000000, 16);
    send(0, 16'h4000, 64'h40D0000000000000, 2);
    send(0, 16'h0003, 64'h4008000000000000, 15);
    send(0, 16'h8000, 64'hC0E0000000000000, 1);
    send(0, 16'hFFFF, 64'hBFF0000000000000, 16);
    send(0, 16'h0000, 64'h0000000000000000, 1);
    send(0, 16'h7FFF, 64'h40DFFFC000000000, 2);
    send(0, 16'hFFFD, 64'hC008000000000000, 15);

    send(1, 16'h8000, 64'h8000000000000000, 1);
    send(1, 16'h8003, 64'hC008000000000000, 15);
    send(1, 16'h0000, 64'h0000000000000000, 1);
    send(1, 16'h0005, 64'h4014000000000000, 14);

    send(2, 16'h4000, 64'h3FE0000000000000, 2);
    send(2, 16'hC000, 64'hBFE0000000000000, 2);
    send(2, 16'h0001, 64'h3F00000000000000, 16);
    drain();

    // Backpressure: result must hold while the sink stalls
    ordy[0] = 1'b0;
    send(0, 16'h0003, 64'h4008000000000000, -1);
    n = 0;
    while (!ov[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", 64'(ov[0]), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_data", od0, 64'h4008000000000000);
      chk("bp_in_ready", 64'(ir[0]), 64'd0);
      if (i == 1) begin
        idat0 = 16'h1234;
        iv[0] = 1'b1;
      end else begin
        iv[0] = 1'b0;
      end
    end
    chk("bp_still_valid", 64'(ov[0]), 64'd1);
    @(posedge clk);
    #1;
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_out_valid", 64'(ov[0]), 64'd0);
    chk("bp_release_in_ready", 64'(ir[0]), 64'd1);
    repeat (20) @(negedge clk);
    chk("bp_ignored_busy", 64'(bsy[0]), 64'd0);
    drain();

    // Reset in the middle of a long normalisation
    @(negedge clk);
    idat0 = 16'h0001;
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_norm_busy", 64'(bsy[0]), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", 64'(ov[0]), 64'd0);
    chk("abort_busy", 64'(bsy[0]), 64'd0);
    chk("abort_in_ready_in_rst", 64'(ir[0]), 64'd0);
    rst = 1'b0;
    #1;
    chk("abort_in_ready_after", 64'(ir[0]), 64'd1);
    repeat (25) @(negedge clk);

    send(0, 16'h4000, 64'h40D0000000000000, 2);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
